// File: rtl/mvm_result_buffer_if.sv
// rtl/mvm_result_buffer_if.sv - result stream between the ping-pong buffer and its consumer
interface mvm_result_buffer_if #(
  parameter int W = 16
);
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data;
  logic                out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/mvm_result_buffer.sv
// rtl/mvm_result_buffer.sv - two-bank ping-pong capture and drain of mvm result bursts
// Optional MVM_RESULT_RELU_EN: negative words are stored as zero at capture.
module mvm_result_buffer #(
  parameter int k = 8,
  parameter int b = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  done,
  input  logic signed [2*b-1:0] data_in,
  mvm_result_buffer_if.master   ob,
  output logic                  overrun,
  input  logic                  clear_overrun,
  output logic [1:0]            banks_full
);

  localparam int W  = 2 * b;
  localparam int IW = (k > 1) ? $clog2(k) : 1;
  localparam logic [IW-1:0] LAST = IW'(k - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DISCARD} state_t;

  state_t              state, state_n;
  logic [IW-1:0]       cnt, cnt_n;
  logic                wr_bank, wr_bank_n;
  logic [1:0]          full, full_n;
  logic                rd_bank;
  logic [IW-1:0]       rd_idx;
  logic                fill, set_ovr, wr_en;
  logic                hs, release_rd;
  logic signed [W-1:0] cap_word;
  logic signed [W-1:0] mem [2][k];

`ifdef MVM_RESULT_RELU_EN
  assign cap_word = data_in[W-1] ? '0 : data_in;
`else
  assign cap_word = data_in;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    wr_bank_n = wr_bank;
    fill      = 1'b0;
    set_ovr   = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (done) begin
          if (!full[0]) begin
            state_n   = CAPTURE;
            wr_bank_n = 1'b0;
          end else if (!full[1]) begin
            state_n   = CAPTURE;
            wr_bank_n = 1'b1;
          end else begin
            state_n = DISCARD;
            set_ovr = 1'b1;
          end
        end
      end
      CAPTURE: begin
        wr_en = 1'b1;
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          fill    = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      DISCARD: begin
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ob.out_valid = full[rd_bank];
  assign ob.out_last  = ob.out_valid && (rd_idx == LAST);
  assign ob.out_data  = ob.out_valid ? mem[rd_bank][rd_idx] : '0;
  assign hs           = ob.out_valid && ob.out_ready;
  assign release_rd   = hs && (rd_idx == LAST);

  always_comb begin
    full_n = full;
    if (release_rd) full_n[rd_bank] = 1'b0;
    if (fill)       full_n[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_bank    <= 1'b0;
      full       <= 2'b00;
      rd_bank    <= 1'b0;
      rd_idx     <= '0;
      overrun    <= 1'b0;
      banks_full <= 2'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      wr_bank    <= wr_bank_n;
      full       <= full_n;
      banks_full <= {1'b0, full_n[0]} + {1'b0, full_n[1]};
      // With nothing older pending, the freshly filled bank becomes the read bank;
      // this keeps capture order even though fills always pick the lowest free bank.
      if (fill && !(full[rd_bank] && !release_rd))
        rd_bank <= wr_bank;
      else if (release_rd)
        rd_bank <= ~rd_bank;
      if (release_rd)
        rd_idx <= '0;
      else if (hs)
        rd_idx <= rd_idx + 1'b1;
      if (set_ovr)
        overrun <= 1'b1;
      else if (clear_overrun)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset)
      mem[wr_bank][cnt] <= cap_word;
  end

endmodule
